// File: rtl/bcd_pkg.sv
// Shared BCD digit type and constants for the cascaded BCD counter.
package bcd_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_MAX  = 4'd9;
    localparam digit_t BCD_ZERO = 4'd0;

    // True only for the exact terminal code; illegal codes 10..15 never carry.
    function automatic logic is_terminal(input digit_t d);
        return (d == BCD_MAX);
    endfunction

    function automatic logic is_legal(input digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single registered BCD digit: increments on inc, wraps 9->0, recovers illegal codes to 0.
import bcd_pkg::*;

module bcd_digit (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [3:0]   q,
    output logic         carry
);

    digit_t q_q;
    digit_t q_d;

    // Next-state value for the digit register.
    always_comb begin
        q_d = q_q;
        if (inc) begin
            if (is_legal(q_q) && !is_terminal(q_q)) begin
                q_d = q_q + 4'd1;
            end else begin
                q_d = BCD_ZERO;
            end
        end else begin
            q_d = q_q;
        end
    end

    // Digit register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= BCD_ZERO;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc & is_terminal(q_q);

endmodule

// File: rtl/bcd_counter.sv
// Cascaded DECADES-digit BCD counter; each digit's carry enables the next digit.
import bcd_pkg::*;

module bcd_counter #(
    parameter int unsigned DECADES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic [4*DECADES-1:0]   Q,
    output logic                   co
);

    // chain_s[k] is the increment request into digit k; the top entry is the full-scale carry.
    logic [DECADES:0] chain_s;

    assign chain_s[0] = en;

    for (genvar k = 0; k < DECADES; k++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .rst   (rst),
            .inc   (chain_s[k]),
            .q     (Q[4*k +: 4]),
            .carry (chain_s[k+1])
        );
    end

    assign co = chain_s[DECADES];

endmodule

// File: tb/tb_bcd_counter.sv
// Directed self-checking bench for bcd_counter at DECADES = 1, 2 and 3.
`timescale 1ns/1ps

module tb_bcd_counter;

    logic        clk;
    logic        rst1, en1, co1;
    logic [3:0]  q1;
    logic        rst2, en2, co2;
    logic [7:0]  q2;
    logic        rst3, en3, co3;
    logic [11:0] q3;

    int tests;
    int fails;
    int exp_q;

    bcd_counter #(.DECADES(1)) dut1 (.clk(clk), .rst(rst1), .en(en1), .Q(q1), .co(co1));
    bcd_counter #(.DECADES(2)) dut2 (.clk(clk), .rst(rst2), .en(en2), .Q(q2), .co(co2));
    bcd_counter #(.DECADES(3)) dut3 (.clk(clk), .rst(rst3), .en(en3), .Q(q3), .co(co3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst1 = 1'b1; en1 = 1'b0;
        rst2 = 1'b1; en2 = 1'b0;
        rst3 = 1'b1; en3 = 1'b0;

        // Asynchronous reset effect before any clock edge.
        #1;
        check("d1_reset_q", {28'd0, q1}, 32'h0);
        check("d1_reset_co", {31'd0, co1}, 32'h0);

        // Modulo-10 sequence over 30 edges.
        tick();
        rst1 = 1'b0;
        en1  = 1'b1;
        exp_q = 0;
        for (int i = 0; i < 30; i++) begin
            check("d1_seq_co", {31'd0, co1}, (exp_q == 9) ? 32'h1 : 32'h0);
            tick();
            exp_q = (exp_q + 1) % 10;
            check("d1_seq_q", {28'd0, q1}, exp_q);
        end
        check("d1_after30", {28'd0, q1}, 32'h0);

        // Hold with en=0 at 5.
        for (int i = 0; i < 5; i++) tick();
        check("d1_at5", {28'd0, q1}, 32'h5);
        en1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("d1_hold_q", {28'd0, q1}, 32'h5);
            check("d1_hold_co", {31'd0, co1}, 32'h0);
        end
        en1 = 1'b1;
        tick();
        check("d1_resume", {28'd0, q1}, 32'h6);
        tick();
        check("d1_at7", {28'd0, q1}, 32'h7);

        // Mid-cycle asynchronous reset, held across two enabled edges.
        #3;
        rst1 = 1'b1;
        #1;
        check("d1_async_rst_q", {28'd0, q1}, 32'h0);
        check("d1_async_rst_co", {31'd0, co1}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("d1_rst_hold_q", {28'd0, q1}, 32'h0);
            check("d1_rst_hold_co", {31'd0, co1}, 32'h0);
        end
        rst1 = 1'b0;
        tick();
        check("d1_first_after_rst", {28'd0, q1}, 32'h1);
        en1 = 1'b0;

        // Two decades.
        rst2 = 1'b0;
        en2  = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            if (i == 99) check("d2_co_at98", {31'd0, co2}, 32'h0);
            tick();
            if (i == 10) check("d2_q10", {24'd0, q2}, 32'h10);
            if (i == 19) check("d2_q19", {24'd0, q2}, 32'h19);
            if (i == 90) check("d2_q90", {24'd0, q2}, 32'h90);
            if (i == 99) begin
                check("d2_q99", {24'd0, q2}, 32'h99);
                check("d2_co99", {31'd0, co2}, 32'h1);
            end
            if (i == 100) begin
                check("d2_wrap_q", {24'd0, q2}, 32'h00);
                check("d2_wrap_co", {31'd0, co2}, 32'h0);
            end
        end
        en2 = 1'b0;
        check("d2_co_en0", {31'd0, co2}, 32'h0);

        // Three decades.
        rst3 = 1'b0;
        en3  = 1'b1;
        for (int i = 1; i <= 1000; i++) begin
            if (i == 999) check("d3_co_at998", {31'd0, co3}, 32'h0);
            tick();
            if (i == 100) check("d3_q100", {20'd0, q3}, 32'h100);
            if (i == 999) begin
                check("d3_q999", {20'd0, q3}, 32'h999);
                check("d3_co999", {31'd0, co3}, 32'h1);
            end
            if (i == 1000) begin
                check("d3_wrap_q", {20'd0, q3}, 32'h000);
                check("d3_wrap_co", {31'd0, co3}, 32'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
